// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core. It covers E-stage forwarding,
// load-use, RAW and MDU stalls, branch flushes, and the stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int MDU_LAT   = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              RegWrite_E,
  input  logic              MemRead_E,
  input  logic              MDU_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic              PCSrc_E,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              ID_EX_Write,
  output logic              Flush_FD,
  output logic              Flush_DE,
  output logic              Flush_EM,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MCW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [MCW-1:0]   MDU_LAST = MCW'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [MCW-1:0] mdu_cnt;
  logic           mdu_hold;
  logic           lu;
  logic           raw;
  logic           rd_E_used;
  logic           rd_M_used;
  logic           rd_W_used;
  logic           stall_ev;
  logic           flush_ev;

  // x0 is hard-wired zero, so it is never a real producer.
  function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rdm,
                                         input logic              we_w,
                                         input logic [REG_AW-1:0] rdw);
    if (FWD_EN == 0)                return 2'b00;
    else if (we_m && reg_match(rdm, rs)) return 2'b10;
    else if (we_w && reg_match(rdw, rs)) return 2'b01;
    else                            return 2'b00;
  endfunction

  always_comb begin
    rd_E_used = (use_rs1_D && reg_match(rd_E, rs1_D)) || (use_rs2_D && reg_match(rd_E, rs2_D));
    rd_M_used = (use_rs1_D && reg_match(rd_M, rs1_D)) || (use_rs2_D && reg_match(rd_M, rs2_D));
    rd_W_used = (use_rs1_D && reg_match(rd_W, rs1_D)) || (use_rs2_D && reg_match(rd_W, rs2_D));
  end

  // Without forwarding, every in-flight producer interlocks; W only if the RF cannot bypass.
  always_comb begin
    lu       = MemRead_E && RegWrite_E && rd_E_used;
    raw      = 1'b0;
    if (FWD_EN == 0) begin
      raw = (RegWrite_E && rd_E_used) || (RegWrite_M && rd_M_used) ||
            ((RF_BYPASS == 0) && RegWrite_W && rd_W_used);
    end
    mdu_hold = MDU_E && (mdu_cnt != MDU_LAST);
  end

  always_comb begin
    ForwardA_E  = fwd_sel(rs1_E, RegWrite_M, rd_M, RegWrite_W, rd_W);
    ForwardB_E  = fwd_sel(rs2_E, RegWrite_M, rd_M, RegWrite_W, rd_W);
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    Flush_FD    = 1'b0;
    Flush_DE    = 1'b0;
    Flush_EM    = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (rst) begin
      ForwardA_E  = 2'b00;
      ForwardB_E  = 2'b00;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      Flush_FD    = 1'b1;
      Flush_DE    = 1'b1;
      Flush_EM    = 1'b1;
    end else if (PCSrc_E) begin
      Flush_FD = 1'b1;
      Flush_DE = 1'b1;
      flush_ev = 1'b1;
    end else if (mdu_hold) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      Flush_EM    = 1'b1;
      stall_ev    = 1'b1;
    end else if (lu || raw) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Flush_DE    = 1'b1;
      stall_ev    = 1'b1;
    end
  end

  // The MDU op is released on its last cycle, which also rearms the count for the next op.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_cnt <= '0;
    end else if (mdu_hold) begin
      mdu_cnt <= mdu_cnt + MCW'(1);
    end else if (MDU_E) begin
      mdu_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share one stimulus stream and are
// checked against a cycle-level reference model, directed tables and corner sequences.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst, clr;
    logic [4:0] rs1_D, rs2_D;
    logic       use1, use2;
    logic [4:0] rs1_E, rs2_E, rd_E;
    logic       rwE, mrE, mduE;
    logic [4:0] rd_M;
    logic       rwM;
    logic [4:0] rd_W;
    logic       rwW, pcsrc;
  } in_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic       pc, ifid, idex, ffd, fde, fem;
    logic       hold, stall_ev, flush_ev;
  } exp_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [9:0] outs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, cnt_clr;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       use_rs1_D, use_rs2_D, RegWrite_E, MemRead_E, MDU_E;
  logic       RegWrite_M, RegWrite_W, PCSrc_E;

  logic [1:0] fa_o [3];
  logic [1:0] fb_o [3];
  logic       pc_o [3], ifid_o [3], idex_o [3], ffd_o [3], fde_o [3], fem_o [3];
  logic [3:0] sc_o [3];
  logic [3:0] fc_o [3];

  int checks = 0;
  int errors = 0;

  int fwd_p [3] = '{1, 0, 0};
  int byp_p [3] = '{1, 0, 1};
  int lat_p [3] = '{4, 4, 1};
  int m_mcnt [3];
  int m_scnt [3];
  int m_fcnt [3];
  bit m_valid = 1'b0;
  localparam int CMAX = 15;

  always #5 clk = ~clk;

  // Instance 0: forwarding on; 1: interlock with no RF bypass; 2: interlock with bypass, single-cycle MDU.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .REG_AW(5), .FWD_EN(g == 0 ? 1 : 0), .RF_BYPASS(g == 1 ? 0 : 1),
      .MDU_LAT(g == 2 ? 1 : 4), .CNT_W(4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .MDU_E(MDU_E),
      .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .PCSrc_E(PCSrc_E), .cnt_clr(cnt_clr),
      .ForwardA_E(fa_o[g]), .ForwardB_E(fb_o[g]),
      .PC_Write(pc_o[g]), .IF_ID_Write(ifid_o[g]), .ID_EX_Write(idex_o[g]),
      .Flush_FD(ffd_o[g]), .Flush_DE(fde_o[g]), .Flush_EM(fem_o[g]),
      .stall_cnt(sc_o[g]), .flush_cnt(fc_o[g])
    );
  end

  function automatic in_t idle();
    in_t v;
    v = '{rst: 1'b0, clr: 1'b0, rs1_D: 5'd0, rs2_D: 5'd0, use1: 1'b0, use2: 1'b0,
          rs1_E: 5'd0, rs2_E: 5'd0, rd_E: 5'd0, rwE: 1'b0, mrE: 1'b0, mduE: 1'b0,
          rd_M: 5'd0, rwM: 1'b0, rd_W: 5'd0, rwW: 1'b0, pcsrc: 1'b0};
    return v;
  endfunction

  function automatic bit same_reg(logic [4:0] rd, logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  // Does the D instruction actually read the register a producer is writing?
  function automatic bit d_reads(in_t v, logic [4:0] rd);
    return (v.use1 && same_reg(rd, v.rs1_D)) || (v.use2 && same_reg(rd, v.rs2_D));
  endfunction

  function automatic logic [1:0] newest_src(in_t v, logic [4:0] rs, int fwd);
    if (fwd == 0) return 2'b00;
    if (v.rwM && same_reg(v.rd_M, rs)) return 2'b10;
    if (v.rwW && same_reg(v.rd_W, rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t ref_model(in_t v, int fwd, int byp, int lat, int mcnt);
    exp_t e;
    bit   lu, raw;
    lu  = v.mrE && v.rwE && d_reads(v, v.rd_E);
    raw = (fwd == 0) && ((v.rwE && d_reads(v, v.rd_E)) || (v.rwM && d_reads(v, v.rd_M)) ||
                         (byp == 0 && v.rwW && d_reads(v, v.rd_W)));
    e.hold = v.mduE && (mcnt != lat - 1);
    e.fa = newest_src(v, v.rs1_E, fwd);
    e.fb = newest_src(v, v.rs2_E, fwd);
    {e.pc, e.ifid, e.idex, e.ffd, e.fde, e.fem} = 6'b111000;
    e.stall_ev = 1'b0;
    e.flush_ev = 1'b0;
    if (v.rst) begin
      e.fa = 2'b00; e.fb = 2'b00;
      {e.pc, e.ifid, e.idex, e.ffd, e.fde, e.fem} = 6'b000111;
    end else if (v.pcsrc) begin
      {e.ffd, e.fde} = 2'b11;
      e.flush_ev = 1'b1;
    end else if (e.hold) begin
      {e.pc, e.ifid, e.idex, e.fem} = 4'b0001;
      e.stall_ev = 1'b1;
    end else if (lu || raw) begin
      {e.pc, e.ifid, e.fde} = 3'b001;
      e.stall_ev = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [9:0] observed(int i);
    return {fa_o[i], fb_o[i], pc_o[i], ifid_o[i], idex_o[i], ffd_o[i], fde_o[i], fem_o[i]};
  endfunction

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, compare every instance, then advance the model past the rising edge.
  task automatic applyStimulus(input in_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; cnt_clr = v.clr;
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; use_rs1_D = v.use1; use_rs2_D = v.use2;
    rs1_E = v.rs1_E; rs2_E = v.rs2_E; rd_E = v.rd_E;
    RegWrite_E = v.rwE; MemRead_E = v.mrE; MDU_E = v.mduE;
    rd_M = v.rd_M; RegWrite_M = v.rwM; rd_W = v.rd_W; RegWrite_W = v.rwW; PCSrc_E = v.pcsrc;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = ref_model(v, fwd_p[i], byp_p[i], lat_p[i], m_mcnt[i]);
      checkOutput($sformatf("outs_dut%0d", i), observed(i),
                  {e.fa, e.fb, e.pc, e.ifid, e.idex, e.ffd, e.fde, e.fem});
      if (m_valid) begin
        checkOutput($sformatf("stall_cnt_dut%0d", i), sc_o[i], m_scnt[i]);
        checkOutput($sformatf("flush_cnt_dut%0d", i), fc_o[i], m_fcnt[i]);
      end
      if (v.rst) m_mcnt[i] = 0;
      else if (e.hold) m_mcnt[i]++;
      else if (v.mduE) m_mcnt[i] = 0;
      if (v.rst || v.clr) begin
        m_scnt[i] = 0;
        m_fcnt[i] = 0;
      end else begin
        if (e.stall_ev && m_scnt[i] < CMAX) m_scnt[i]++;
        if (e.flush_ev && m_fcnt[i] < CMAX) m_fcnt[i]++;
      end
    end
    if (v.rst) m_valid = 1'b1;
  endtask

  initial begin
    vec_t tbl [9];
    in_t  v;
    in_t  rv;
    logic [3:0] mdu_idex;

    v = idle(); v.rs1_E = 5; v.rd_M = 5; v.rd_W = 5; v.rwM = 1; v.rwW = 1;
    tbl[0] = '{"fwd_m_priority", v, 10'b10_00_111_000};
    v.rwM = 0;
    tbl[1] = '{"fwd_w", v, 10'b01_00_111_000};
    v = idle(); v.rwM = 1; v.rwW = 1;
    tbl[2] = '{"fwd_x0", v, 10'b00_00_111_000};
    v = idle(); v.mrE = 1; v.rwE = 1; v.rd_E = 7; v.rs2_D = 7; v.use2 = 1;
    tbl[3] = '{"load_use", v, 10'b00_00_001_010};
    v.pcsrc = 1;
    tbl[4] = '{"branch_beats_lu", v, 10'b00_00_111_110};
    v.pcsrc = 0; v.use2 = 0;
    tbl[5] = '{"lu_unused_src", v, 10'b00_00_111_000};
    v = idle(); v.rs2_E = 9; v.rd_W = 9; v.rwW = 1;
    tbl[6] = '{"fwd_b_w", v, 10'b00_01_111_000};
    v = idle(); v.mrE = 1; v.rwE = 1; v.use1 = 1;
    tbl[7] = '{"lu_x0", v, 10'b00_00_111_000};
    v = idle(); v.rs1_E = 4; v.rs2_E = 4; v.rd_M = 4; v.rd_W = 4; v.rwM = 1; v.rwW = 1;
    tbl[8] = '{"fwd_both_m", v, 10'b10_10_111_000};

    v = idle(); v.rst = 1;
    applyStimulus(v);
    checkOutput("reset_outs", observed(0), 10'b00_00_000_111);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(tbl[k].v);
      checkOutput(tbl[k].name, observed(0), tbl[k].outs);
    end

    // Load-use stall costs one count; branch with load-use counts only as a flush.
    v = idle(); v.clr = 1;
    applyStimulus(v);
    applyStimulus(tbl[3].v);
    applyStimulus(tbl[4].v);
    applyStimulus(idle());
    checkOutput("lu_stall_cnt", sc_o[0], 1);
    checkOutput("br_flush_cnt", fc_o[0], 1);

    // MDU op of latency 4: three held cycles then release.
    v = idle(); v.rst = 1;
    applyStimulus(v);
    v = idle(); v.clr = 1;
    applyStimulus(v);
    v = idle(); v.mduE = 1; v.rd_E = 6; v.rwE = 1;
    mdu_idex = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(v);
      checkOutput($sformatf("mdu_idex_c%0d", k), idex_o[0], mdu_idex[3-k]);
      checkOutput($sformatf("mdu_fem_c%0d", k), fem_o[0], !mdu_idex[3-k]);
      checkOutput($sformatf("mdu_lat1_idex_c%0d", k), idex_o[2], 1);
    end
    applyStimulus(idle());
    checkOutput("mdu_stall_cnt", sc_o[0], 3);

    // Reset in the second MDU cycle forces a full recount.
    v = idle(); v.mduE = 1;
    applyStimulus(v);
    v.rst = 1;
    applyStimulus(v);
    v.rst = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(v);
      checkOutput($sformatf("mdu_rst_idex_c%0d", k), idex_o[0], mdu_idex[3-k]);
    end

    // Interlock mode: W-stage dependency stalls only without RF bypass.
    v = idle(); v.rd_W = 3; v.rwW = 1; v.rs1_D = 3; v.use1 = 1; v.rs1_E = 3;
    applyStimulus(v);
    checkOutput("raw_w_nobyp_pc", pc_o[1], 0);
    checkOutput("raw_w_byp_pc", pc_o[2], 1);
    checkOutput("raw_fwd_off_fa", fa_o[1], 0);

    // Counter saturation at 15, then clear beats a concurrent stall.
    v = idle(); v.clr = 1;
    applyStimulus(v);
    for (int k = 0; k < 20; k++) applyStimulus(tbl[3].v);
    v = tbl[3].v; v.clr = 1;
    applyStimulus(v);
    checkOutput("stall_cnt_sat", sc_o[0], 15);
    applyStimulus(idle());
    checkOutput("stall_cnt_clr", sc_o[0], 0);

    for (int k = 0; k < 400; k++) begin
      rv = idle();
      rv.rst   = ($urandom_range(0, 39) == 0);
      rv.clr   = ($urandom_range(0, 29) == 0);
      rv.rs1_D = 5'($urandom_range(0, 3)); rv.rs2_D = 5'($urandom_range(0, 3));
      rv.use1  = 1'($urandom_range(0, 1)); rv.use2  = 1'($urandom_range(0, 1));
      rv.rs1_E = 5'($urandom_range(0, 3)); rv.rs2_E = 5'($urandom_range(0, 3));
      rv.rd_E  = 5'($urandom_range(0, 3)); rv.rd_M  = 5'($urandom_range(0, 3));
      rv.rd_W  = 5'($urandom_range(0, 3));
      rv.rwE   = 1'($urandom_range(0, 1)); rv.mrE = 1'($urandom_range(0, 1));
      rv.rwM   = 1'($urandom_range(0, 1)); rv.rwW = 1'($urandom_range(0, 1));
      rv.mduE  = ($urandom_range(0, 2) == 0);
      rv.pcsrc = ($urandom_range(0, 5) == 0);
      applyStimulus(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (F/D/E/M/W). It extends the plain E-stage forwarding selector with several functions:
- load-use stall detection;
- branch flush;
- a multi-cycle E-stage (MDU) hold with an internal latency counter;
- a no-forwarding mode that falls back to RAW interlocks;
- saturating stall/flush performance counters.

It drives every pipeline-register enable and flush in the core.

## Interface
Parameters:
- REG_AW, 5, register-address width
- FWD_EN, 1, 1 = M/W→E forwarding enabled; 0 = forwarding muxes forced to 00 and RAW hazards resolved by stalling
- RF_BYPASS, 1, 1 = register file returns same-cycle write data (no W-stage interlock needed when FWD_EN=0)
- MDU_LAT, 4, cycles an MDU op occupies E (≥1)
- CNT_W, 16, performance-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1_D, rs2_D  in  REG_AW  D-stage source registers
- use_rs1_D, use_rs2_D  in  1  D instruction actually reads rs1/rs2
- rs1_E, rs2_E, rd_E  in  REG_AW  E-stage register fields
- RegWrite_E, MemRead_E, MDU_E  in  1  E-stage control
- rd_M, rd_W  in  REG_AW; RegWrite_M, RegWrite_W  in  1
- PCSrc_E  in  1  taken branch/jump resolved in E
- cnt_clr  in  1  synchronous clear of performance counters
- ForwardA_E, ForwardB_E  out  2  00 = regfile, 10 = ALU_result_M, 01 = Result_W
- PC_Write, IF_ID_Write, ID_EX_Write  out  1  register enables
- Flush_FD, Flush_DE, Flush_EM  out  1  insert bubble into IF/ID, ID/EX, EX/MEM
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Register x0 never matches: any compare against rd = 0 is false.
- Forwarding (FWD_EN=1):
  - ForwardA_E = 10 if RegWrite_M & rd_M==rs1_E;
  - else 01 if RegWrite_W & rd_W==rs1_E;
  - else 00. ForwardB_E is the same using rs2_E.
  - M has priority over W.
- Hazard terms (combinational):
  - lu: load-use. MemRead_E & RegWrite_E & rd_E matches a used D source.
  - raw (FWD_EN=0 only): a used D source matches rd_E (RegWrite_E) or rd_M (RegWrite_M), or rd_W (RegWrite_W) when RF_BYPASS=0. With FWD_EN=1, raw=0.
  - mdu_hold: MDU_E & (mdu_cnt != MDU_LAT-1).
- MDU counter mdu_cnt (width clog2(MDU_LAT), min 1):
  - 0 at reset;
  - increments while mdu_hold;
  - returns to 0 in the cycle MDU_E is seen with mdu_cnt == MDU_LAT-1.
  - MDU_LAT=1 → mdu_hold never asserts.
- Output priority, highest first:
  1. rst: PC_Write=IF_ID_Write=ID_EX_Write=0; all Flush=1; forwards 00.
  2. PCSrc_E: Flush_FD=1, Flush_DE=1; all enables 1. Any lu/raw is discarded because the D instruction is squashed.
  3. mdu_hold: PC_Write=IF_ID_Write=ID_EX_Write=0, Flush_EM=1.
  4. lu | raw: PC_Write=IF_ID_Write=0, Flush_DE=1, ID_EX_Write=1.
  5. Otherwise: all enables 1, all flushes 0.
- Counters:
  - stall_cnt +1 each cycle case 3 or 4 is active;
  - flush_cnt +1 each cycle case 2 is active;
  - both saturate at 2^CNT_W−1;
  - both are zeroed by rst or cnt_clr. cnt_clr beats a same-cycle increment.

## Timing
- Forward selects, enables and flushes are combinational from the current-cycle inputs, with zero latency.
- Counters and mdu_cnt update at the clock edge. Counter outputs reflect events up to the previous cycle.
- An MDU op stays in E for exactly MDU_LAT cycles. The dependent D instruction enters E on the cycle after release.
- Load-use costs exactly 1 bubble. A taken branch costs exactly 2 squashed slots.
- rst asserted mid-MDU: mdu_cnt = 0 next cycle. After rst deasserts, a still-present MDU_E restarts a full MDU_LAT count.
- Reset values: mdu_cnt 0, stall_cnt 0, flush_cnt 0.

## Test plan
- Forwarding: rs1_E=5, rd_M=5, rd_W=5, RegWrite_M=RegWrite_W=1 → ForwardA_E=10. Drop RegWrite_M → 01. Set rd_M=rd_W=0 and rs1_E=0 → 00.
- Load-use: MemRead_E=1, rd_E=7, rs2_D=7, use_rs2_D=1 → one cycle with PC_Write=0, IF_ID_Write=0, Flush_DE=1; stall_cnt +1. With use_rs2_D=0 → no stall.
- Branch vs load-use: PCSrc_E=1 together with lu-matching inputs → Flush_FD=Flush_DE=1, PC_Write=1; flush_cnt +1, stall_cnt unchanged.
- MDU, MDU_LAT=4: hold MDU_E=1 → mdu_hold for 3 cycles (ID_EX_Write=0, Flush_EM=1), release on 4th; stall_cnt=3. Assert rst in the 2nd cycle → mdu_cnt 0 and a full recount afterwards.
- FWD_EN=0, RF_BYPASS=0: rd_W=3, RegWrite_W=1, rs1_D=3, use_rs1_D=1 → stall. With RF_BYPASS=1 → no stall. ForwardA/B stay 00 throughout.
- Counters, CNT_W=4: 20 consecutive stall cycles → stall_cnt=15 (saturated). cnt_clr concurrent with a stall → 0.
